// File: rtl/lcd_init_sequencer_pkg.sv
// Shared types and constants for the HD44780 8-bit write-only sequencer:
// FSM state encodings, the power-on init ROM and common command bytes.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_SETUP,
        INIT_PULSE,
        INIT_WAIT,
        IDLE,
        SETUP,
        PULSE,
        WAIT
    } state_t;

    // Phases of the shared write timer (power-up delay plus one write cycle)
    typedef enum logic [2:0] {
        PH_PWR,
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } phase_t;

    localparam logic [7:0] LCD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;

    localparam int INIT_LEN   = 7;
    localparam int INIT_IDX_W = 3;

    // Entry 0 is the rightmost element
    localparam logic [INIT_LEN-1:0][7:0] INIT_BYTES = {
        LCD_ENTRY_INC, LCD_CLEAR, LCD_DISP_ON,
        LCD_FUNC_8BIT_2L, LCD_FUNC_8BIT_2L, LCD_FUNC_8BIT_2L, LCD_FUNC_8BIT_2L
    };

    // Long execution wait for the first three function-set writes and the clear
    localparam logic [INIT_LEN-1:0] INIT_LONG = 7'b010_0111;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution time
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_init_sequencer_write_timer.sv
// Shared write timer: owns the single down-counter and the LCD pin
// registers. Counts the power-up delay after reset, then runs one
// setup / E-pulse / execution-wait cycle per start strobe.
module lcd_write_timer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 1000000,
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int SHORT_WAIT_CYC = 1250,
    parameter int LONG_WAIT_CYC  = 125000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_long,
    output logic       o_lcd_rs,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_data,
    output logic       o_setup_end,
    output logic       o_pulse_end,
    output logic       o_done
);

    localparam int MAXC = max_of(max_of(max_of(POWERUP_CYC, SETUP_CYC),
                                        max_of(E_PULSE_CYC, SHORT_WAIT_CYC)),
                                 LONG_WAIT_CYC);
    localparam int CW = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(E_PULSE_CYC - 1);
    localparam logic [CW-1:0] SHORT_LD = CW'(SHORT_WAIT_CYC - 1);
    localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT_CYC - 1);

    phase_t        r_phase;
    logic [CW-1:0] r_cnt;
    logic          r_long;
    logic          r_rs;
    logic          r_e;
    logic [7:0]    r_data;

    logic w_zero;
    logic w_pwr_end;
    logic w_accept;

    assign w_zero      = (r_cnt == '0);
    assign w_pwr_end   = (r_phase == PH_PWR) && (r_cnt == PWR_LAST);
    assign o_setup_end = (r_phase == PH_SETUP) && w_zero;
    assign o_pulse_end = (r_phase == PH_PULSE) && w_zero;
    assign o_done      = w_pwr_end || ((r_phase == PH_WAIT) && w_zero);
    // A start is taken when idle or on the last cycle of a wait, so chained
    // writes follow each other with no dead cycle
    assign w_accept    = i_start && ((r_phase == PH_IDLE) || o_done);

    assign o_lcd_rs   = r_rs;
    assign o_lcd_e    = r_e;
    assign o_lcd_data = r_data;

    // Phase sequencing and counter; power-up counts up from the reset value 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= PH_PWR;
            r_cnt   <= '0;
            r_long  <= 1'b0;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
            r_data  <= 8'h00;
        end else if (w_accept) begin
            r_phase <= PH_SETUP;
            r_cnt   <= SETUP_LD;
            r_rs    <= i_rs;
            r_data  <= i_data;
            r_long  <= i_long;
        end else begin
            case (r_phase)
                PH_PWR: begin
                    if (w_pwr_end) begin
                        r_phase <= PH_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PH_IDLE: ;
                PH_SETUP: begin
                    if (w_zero) begin
                        r_phase <= PH_PULSE;
                        r_e     <= 1'b1;
                        r_cnt   <= PULSE_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PH_PULSE: begin
                    if (w_zero) begin
                        r_phase <= PH_WAIT;
                        r_e     <= 1'b0;
                        r_cnt   <= r_long ? LONG_LD : SHORT_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PH_WAIT: begin
                    if (w_zero) begin
                        r_phase <= PH_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_init_sequencer.sv
// HD44780 8-bit write-only controller: runs the power-on init ROM, then
// accepts instruction/data bytes over valid/ready and drives RS/E/data.
// Optional build macro LCD_ESCAPE_EN: RS is taken from an in-band 0x00
// escape prefix instead of i_cmd_rs.
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 1000000,
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int SHORT_WAIT_CYC = 1250,
    parameter int LONG_WAIT_CYC  = 125000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    output logic       o_init_done,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_data
);

    localparam logic [INIT_IDX_W-1:0] LAST_IDX = INIT_IDX_W'(INIT_LEN - 1);

    state_t                r_state;
    logic [INIT_IDX_W-1:0] r_idx;
    logic                  r_ready;
    logic                  r_init_done;

    logic                  w_accept;
    logic                  w_host_rs;
    logic                  w_host_skip;
    logic [INIT_IDX_W-1:0] w_next_idx;
    logic                  w_start;
    logic                  w_rs;
    logic [7:0]            w_data;
    logic                  w_long;
    logic                  w_setup_end;
    logic                  w_pulse_end;
    logic                  w_done;

    assign w_accept   = i_cmd_valid && r_ready;
    assign w_next_idx = r_idx + 1'b1;

`ifdef LCD_ESCAPE_EN
    logic r_esc;
    // A bare 0x00 only arms the escape; the byte after it is an instruction
    assign w_host_rs   = ~r_esc;
    assign w_host_skip = (i_cmd_data == 8'h00) && !r_esc;
`else
    assign w_host_rs   = i_cmd_rs;
    assign w_host_skip = 1'b0;
`endif

    // Select which byte (init ROM or host) is handed to the write timer
    always_comb begin
        w_start = 1'b0;
        w_rs    = 1'b0;
        w_data  = 8'h00;
        w_long  = 1'b0;
        case (r_state)
            PWR_WAIT: begin
                if (w_done) begin
                    w_start = 1'b1;
                    w_data  = INIT_BYTES[0];
                    w_long  = INIT_LONG[0];
                end
            end
            INIT_WAIT: begin
                if (w_done && (r_idx != LAST_IDX)) begin
                    w_start = 1'b1;
                    w_data  = INIT_BYTES[w_next_idx];
                    w_long  = INIT_LONG[w_next_idx];
                end
            end
            IDLE: begin
                if (w_accept && !w_host_skip) begin
                    w_start = 1'b1;
                    w_rs    = w_host_rs;
                    w_data  = i_cmd_data;
                    w_long  = is_long_cmd(w_host_rs, i_cmd_data);
                end
            end
            default: ;
        endcase
    end

    lcd_write_timer #(
        .POWERUP_CYC   (POWERUP_CYC),
        .SETUP_CYC     (SETUP_CYC),
        .E_PULSE_CYC   (E_PULSE_CYC),
        .SHORT_WAIT_CYC(SHORT_WAIT_CYC),
        .LONG_WAIT_CYC (LONG_WAIT_CYC)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_start),
        .i_rs       (w_rs),
        .i_data     (w_data),
        .i_long     (w_long),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_e    (o_lcd_e),
        .o_lcd_data (o_lcd_data),
        .o_setup_end(w_setup_end),
        .o_pulse_end(w_pulse_end),
        .o_done     (w_done)
    );

    // Main sequencer FSM: tracks timer phases, walks the ROM, owns handshake
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= PWR_WAIT;
            r_idx       <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
`ifdef LCD_ESCAPE_EN
            r_esc       <= 1'b0;
`endif
        end else begin
            case (r_state)
                PWR_WAIT: begin
                    if (w_done) begin
                        r_state <= INIT_SETUP;
                        r_idx   <= '0;
                    end
                end
                INIT_SETUP: if (w_setup_end) r_state <= INIT_PULSE;
                INIT_PULSE: if (w_pulse_end) r_state <= INIT_WAIT;
                INIT_WAIT: begin
                    if (w_done) begin
                        if (r_idx == LAST_IDX) begin
                            r_state     <= IDLE;
                            r_init_done <= 1'b1;
                            r_ready     <= 1'b1;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_state <= INIT_SETUP;
                        end
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (!w_host_skip) begin
                            r_state <= SETUP;
                        end
`ifdef LCD_ESCAPE_EN
                        r_esc <= w_host_skip;
`endif
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SETUP: if (w_setup_end) r_state <= PULSE;
                PULSE: if (w_pulse_end) r_state <= WAIT;
                WAIT: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= PWR_WAIT;
            endcase
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_init_done = r_init_done;
    assign o_lcd_rw    = 1'b0;

endmodule

// File: doc/lcd_init_sequencer.md
Name: lcd_init_sequencer

Overview:
Controller for an HD44780-compatible character LCD in 8-bit, write-only mode. After reset it runs the power-on initialisation sequence autonomously. It then accepts instruction/data bytes over a valid/ready handshake and generates RS/E/data timing itself. Each byte is followed by the execution wait that its command class requires. It sits between a byte source (UART deserializer or CPU register) and the LCD pins.

Parameters:
POWERUP_CYC, 1000000, clocks to wait after reset before the first write (40 ms at 25 MHz)
SETUP_CYC, 2, clocks RS/data are stable before E rises
E_PULSE_CYC, 12, clocks E is held high (480 ns at 25 MHz)
SHORT_WAIT_CYC, 1250, post-pulse wait for normal commands and data (50 us)
LONG_WAIT_CYC, 125000, post-pulse wait for clear/home and the first three init writes (5 ms)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  byte offered
cmd_rs  in  1  0 = instruction, 1 = character data
cmd_data  in  8  byte to write
cmd_ready  out  1  sequencer can accept a byte
init_done  out  1  init sequence complete, sticky until reset
lcd_rs  out  1  LCD register select
lcd_rw  out  1  tied 0 (write only)
lcd_e  out  1  LCD enable strobe
lcd_data  out  8  LCD data bus

Behaviour:
- Reset (async, active high): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, cmd_ready=0, init_done=0, state=PWR_WAIT, counter=0.
- Reset mid-operation aborts any write immediately (E drops asynchronously), then the block restarts from PWR_WAIT.
- States: PWR_WAIT -> INIT_SETUP -> INIT_PULSE -> INIT_WAIT (loops over the ROM) -> IDLE -> SETUP -> PULSE -> WAIT -> IDLE.
- PWR_WAIT: count POWERUP_CYC clocks.
- Init ROM, all writes with RS=0: 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - Entries 0, 1, 2 and the 0x01 entry use LONG_WAIT_CYC.
  - All other entries use SHORT_WAIT_CYC.
- After the last init wait, init_done=1 and the block enters IDLE.
- IDLE: cmd_ready=1. A transfer occurs on a rising clk with cmd_valid && cmd_ready.
- After a transfer (cycle N):
  - N+1: cmd_ready=0, lcd_data and lcd_rs latch the byte.
  - lcd_e rises at N+1+SETUP_CYC and stays high exactly E_PULSE_CYC clocks.
  - The WAIT interval is counted from E falling.
  - lcd_data and lcd_rs hold their values until the next accepted byte.
  - cmd_ready reasserts on the cycle after WAIT completes.
- Wait class: LONG_WAIT_CYC when cmd_rs=0 and cmd_data[7:2]==0 (clear 0x01, home 0x02/0x03); SHORT_WAIT_CYC otherwise.
- cmd_valid while cmd_ready=0 is ignored. The source must hold the byte until it sees ready.
- cmd_ready is never 1 before init_done.
- One shared down-counter, width $clog2(max of all cycle parameters)+1. Each phase loads (param-1) and transitions when the counter reaches 0. A parameter value of 1 therefore means one clock; no parameter may be 0.
- lcd_rw is constant 0.

Optional Feature:
LCD_ESCAPE_EN
- Defined: cmd_rs is ignored. An accepted byte 0x00 is not written to the LCD; it arms an escape flag, and cmd_ready reasserts on the next cycle. The next accepted byte is then written with RS=0 and the flag clears. Any other byte is written with RS=1. Escape followed by 0x00 writes instruction 0x00. The flag is cleared by reset.
- Undefined: RS comes from cmd_rs and 0x00 is ordinary data.

Decomposition:
- Package lcd_pkg holds:
  - state enum (PWR_WAIT, INIT_SETUP, INIT_PULSE, INIT_WAIT, IDLE, SETUP, PULSE, WAIT)
  - init ROM constants (INIT_LEN=7, INIT_BYTES array, per-entry long-wait flags)
  - command localparams LCD_CLEAR=0x01, LCD_FUNC_8BIT_2L=0x38, LCD_DISP_ON=0x0C, LCD_ENTRY_INC=0x06
- One sub-module, lcd_write_timer: takes a start strobe, rs, data and a long flag; runs setup/pulse/wait; returns done. Both the init path and the host path share it.

Test Plan:
All scenarios use POWERUP_CYC=100, SETUP_CYC=2, E_PULSE_CYC=4, SHORT_WAIT_CYC=20, LONG_WAIT_CYC=200.
- Release reset -> no E pulse for 100 clocks; then exactly 7 E pulses of 4 clocks each with data 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and RS=0; init_done=1; cmd_ready=1 only after that; gap between E falling and the next setup start is 200/200/200/20/20/200/20.
- After init, send rs=1, data=0x41 -> cmd_ready low at N+1; lcd_data=0x41, RS=1 at N+1; E high on clocks N+3..N+6; cmd_ready high again 20 clocks after E falls.
- Send rs=0, data=0x01, then rs=0, data=0x80 -> waits of 200 and 20 clocks respectively.
- Hold cmd_valid high with bytes 0x48, 0x49 back-to-back -> exactly one transfer per ready window; no byte lost or duplicated; each byte is held until accepted.
- Assert rst during the E-high phase of a data write -> lcd_e=0 immediately; init_done=0; full power-up plus init sequence repeats.
- (LCD_ESCAPE_EN) Send 0x00, 0x01, 0x42 -> only two E pulses: 0x01 with RS=0 and a 200-clock wait, then 0x42 with RS=1.
